mod_n_updown_counter: RTL
=========================

// Module: mod_n_updown_counter
// PURPOSE
//   Synchronous, parametrised modulo-N up/down counter. It is the successor to the 3-bit and
//   N-bit ripple counters: all flops sit on one clock, so the outputs are glitch-free.
//   Adds direction control, parallel load, clear, a wrap/saturate mode, a terminal-count
//   output, a wrap event pulse, a sticky overflow flag and a registered Gray-code output.
//   Used as the general-purpose event/divider counter in the counter library.
// PARAMETERS
//   WIDTH     4   count register width in bits
//   MODULUS   16  count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
//   SATURATE  0   0 = wrap at the range ends; 1 = hold at the range ends
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      count enable; counts one step per clk while high
//   up_dn        in   1      count direction: 1 = up, 0 = down
//   clear        in   1      synchronous clear to 0
//   load         in   1      synchronous parallel load
//   load_value   in   WIDTH  value written on load
//   count        out  WIDTH  registered binary count
//   count_gray   out  WIDTH  registered Gray code of count (count ^ (count >> 1))
//   tc           out  1      combinational terminal count:
//                            enable & ((up_dn & count==MODULUS-1) | (!up_dn & count==0))
//   wrap_pulse   out  1      registered 1-cycle pulse, asserted the cycle after a wrap occurs
//   overflow     out  1      sticky flag, set by any wrap or saturation hit
// BEHAVIOUR
//   - Reset (sampled at clk edge): count=0, count_gray=0, wrap_pulse=0, overflow=0.
//   - Priority per edge: reset > clear > load > enable. Lower-priority requests in the same
//     cycle are dropped.
//   - clear: count=0, count_gray=0, overflow=0, wrap_pulse=0.
//   - load: count = load_value when load_value <= MODULUS-1, else MODULUS-1 (clamped).
//     A load does not set overflow and does not pulse wrap_pulse.
//   - enable=1 and up_dn=1:
//       count<MODULUS-1  -> count+1
//       count==MODULUS-1 -> 0 if SATURATE=0 (wrap event), or hold if SATURATE=1 (sat event)
//   - enable=1 and up_dn=0:
//       count>0          -> count-1
//       count==0         -> MODULUS-1 if SATURATE=0 (wrap event), or hold if SATURATE=1 (sat event)
//   - enable=0: all registers hold; wrap_pulse returns to 0.
//   - Wrap event: wrap_pulse=1 for exactly the next cycle and overflow set. A saturation
//     event sets overflow but leaves wrap_pulse at 0. overflow is cleared only by reset or clear.
//   - count_gray is registered from the next-count value, so it changes on the same edge as
//     count (zero extra latency). Consecutive values differ in 1 bit, except across a
//     non-power-of-2 wrap.
//   - Latency: count, count_gray, wrap_pulse and overflow update 1 clk after the sampled
//     inputs. tc is combinational, so it has 0 latency.
//   - Direction may change on any cycle. The next step uses the up_dn value sampled at that edge.
//   - Reset or clear mid-count takes effect on that edge, regardless of enable/load.
//   - No internal state beyond count, wrap_pulse and overflow; no FSM beyond the counter itself.
// TESTING
//   1. WIDTH=4, MODULUS=10, SATURATE=0; up for 12 clks from reset -> 0..9,0,1;
//      tc high at 9; wrap_pulse 1 cycle after 9->0; overflow=1.
//   2. Same config, down from 0 -> 9,8,...; wrap_pulse after 0->9; count_gray of 9 = 4'b1101.
//   3. SATURATE=1, MODULUS=10: up from 7 for 5 clks -> 8,9,9,9,9; overflow=1; wrap_pulse stays 0;
//      then down -> 8.
//   4. load with load_value=12, MODULUS=10 -> count=9; load=1 together with enable=1 -> load wins;
//      clear=1 together with load=1 -> count=0.
//   5. Toggle up_dn every cycle from 5 with enable=1 -> 6,5,6,5; enable=0 -> hold; tc=0 while enable=0.
//   6. reset asserted mid-count at 7 with overflow=1 -> next edge: count=0, overflow=0, wrap_pulse=0;
//      verify count_gray == count ^ (count>>1) on every cycle.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with clear, parallel load, wrap or saturate
// at the range ends, a combinational terminal count, a one-cycle wrap pulse, a
// sticky overflow flag and a registered Gray-code copy of the count.
// Legal range: 2 <= MODULUS <= 2**WIDTH.
module mod_n_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Binary to reflected Gray code.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Out-of-range load values are clamped to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v <= MAX_CNT) ? v : MAX_CNT;
  endfunction

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap_pulse;
  logic             r_overflow;

  logic             w_at_max;
  logic             w_at_min;
  logic             w_at_end;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic             w_ovf_next;

  assign w_at_max = (r_count == MAX_CNT);
  assign w_at_min = (r_count == '0);
  assign w_at_end = up_dn ? w_at_max : w_at_min;

  // Terminal count is combinational so a cascaded stage can see it in the same cycle.
  assign tc = enable & w_at_end;

  // Value after one counting step in the sampled direction, honouring wrap/saturate.
  always_comb begin
    w_step = r_count;
    if (up_dn) begin
      if (!w_at_max)          w_step = r_count + ONE;
      else if (SATURATE == 0) w_step = '0;
    end else begin
      if (!w_at_min)          w_step = r_count - ONE;
      else if (SATURATE == 0) w_step = MAX_CNT;
    end
  end

  // Next-state selection: clear beats load beats counting; idle cycles drop the pulse.
  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    w_ovf_next   = r_overflow;
    if (clear) begin
      w_count_next = '0;
      w_ovf_next   = 1'b0;
    end else if (load) begin
      w_count_next = clamp_load(load_value);
    end else if (enable) begin
      w_count_next = w_step;
      // Reaching an end while enabled is either a wrap or a saturation hit.
      w_wrap_next  = w_at_end && (SATURATE == 0);
      w_ovf_next   = r_overflow | w_at_end;
    end
  end

  // State registers; Gray code is taken from the next count so it tracks count with no lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_gray       <= '0;
      r_wrap_pulse <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_count      <= w_count_next;
      r_gray       <= to_gray(w_count_next);
      r_wrap_pulse <= w_wrap_next;
      r_overflow   <= w_ovf_next;
    end
  end

  assign count      = r_count;
  assign count_gray = r_gray;
  assign wrap_pulse = r_wrap_pulse;
  assign overflow   = r_overflow;

endmodule
